// File: rtl/nucleo_pkg.sv
// ============================================================================
// Module      : nucleo_pkg
// Description : Shared state codes, opcodes and decode helpers for the
//               parameterised multicycle core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nucleo_pkg;

    localparam int c_tstep_w = 3;

    typedef enum logic [c_tstep_w-1:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    localparam logic [3:0] c_op_mv   = 4'd0;
    localparam logic [3:0] c_op_mvi  = 4'd1;
    localparam logic [3:0] c_op_add  = 4'd2;
    localparam logic [3:0] c_op_sub  = 4'd3;
    localparam logic [3:0] c_op_and  = 4'd4;
    localparam logic [3:0] c_op_slt  = 4'd5;
    localparam logic [3:0] c_op_ld   = 4'd6;
    localparam logic [3:0] c_op_st   = 4'd7;
    localparam logic [3:0] c_op_mvnz = 4'd8;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == c_op_mvi) || (op == c_op_ld) || (op == c_op_st);
    endfunction

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == c_op_add) || (op == c_op_sub) ||
               (op == c_op_and) || (op == c_op_slt);
    endfunction

    function automatic logic is_illegal_op(input logic [3:0] op);
        return op > c_op_mvnz;
    endfunction

    // mvnz only commits when the last ALU result was non-zero
    function automatic logic writes_rx(input logic [3:0] op, input logic z);
        logic w;
        case (op)
            c_op_mv, c_op_mvi, c_op_add, c_op_sub,
            c_op_and, c_op_slt, c_op_ld: w = 1'b1;
            c_op_mvnz:                   w = ~z;
            default:                     w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/banco_registradores_param.sv
// ============================================================================
// Module      : banco_registradores_param
// Description : NREG x DATA_W register file, two read ports, one write port,
//               top register doubles as PC with its own increment port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module banco_registradores_param #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_x,
    input  logic [REG_AW-1:0] raddr_y,
    input  logic              pc_inc,
    output logic [DATA_W-1:0] rdata_x,
    output logic [DATA_W-1:0] rdata_y,
    output logic [DATA_W-1:0] pc_q
);

    localparam int c_nreg = 2 ** REG_AW;

    logic [DATA_W-1:0] r_regs [c_nreg];

    // The write is issued after the increment so a PC write wins (jump)
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_nreg; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (pc_inc) begin
                r_regs[c_nreg-1] <= r_regs[c_nreg-1] + DATA_W'(1);
            end
            if (we) begin
                r_regs[waddr] <= wdata;
            end
        end
    end

    assign rdata_x = r_regs[raddr_x];
    assign rdata_y = r_regs[raddr_y];
    assign pc_q    = r_regs[c_nreg-1];

endmodule

`default_nettype wire

// File: rtl/nucleo_multiciclo_param.sv
// ============================================================================
// Module      : nucleo_multiciclo_param
// Description : Parameterised multicycle core (FETCH/DECODE/EXEC/MEM/WB) with
//               a req/ack external memory port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nucleo_multiciclo_param
    import nucleo_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int ADDR_W = 6
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Run,
    output logic                 Done,
    output logic [c_tstep_w-1:0] Tstep,
    output logic [DATA_W-1:0]    BusWires,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    input  logic                 mem_ack,
    output logic [DATA_W-1:0]    Rx_data,
    output logic [DATA_W-1:0]    Ry_data,
    output logic                 Illegal
);

    localparam int c_ir_w = 4 + 2 * REG_AW;

    state_t              r_state;
    state_t              w_next_state;
    logic [c_ir_w-1:0]   r_ir;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_g;
    logic                r_z;

    logic [3:0]          w_op;
    logic [REG_AW-1:0]   w_rx;
    logic [REG_AW-1:0]   w_ry;
    logic [DATA_W-1:0]   w_rdata_x;
    logic [DATA_W-1:0]   w_rdata_y;
    logic [DATA_W-1:0]   w_pc;
    logic [DATA_W-1:0]   w_alu;
    logic [DATA_W-1:0]   w_addr_full;
    logic                w_lt;
    logic                w_pc_inc;
    logic                w_rf_we;

    assign w_op = r_ir[c_ir_w-1:2*REG_AW];
    assign w_rx = r_ir[2*REG_AW-1:REG_AW];
    assign w_ry = r_ir[REG_AW-1:0];

    banco_registradores_param #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regs (
        .clk     (Clock),
        .rst     (Reset),
        .we      (w_rf_we),
        .waddr   (w_rx),
        .wdata   (r_g),
        .raddr_x (w_rx),
        .raddr_y (w_ry),
        .pc_inc  (w_pc_inc),
        .rdata_x (w_rdata_x),
        .rdata_y (w_rdata_y),
        .pc_q    (w_pc)
    );

    assign w_lt = $signed(r_a) < $signed(w_rdata_y);

    always_comb begin
        w_alu = '0;
        case (w_op)
            c_op_add:            w_alu = r_a + w_rdata_y;
            c_op_sub:            w_alu = r_a - w_rdata_y;
            c_op_and:            w_alu = r_a & w_rdata_y;
            c_op_slt:            w_alu = {{(DATA_W-1){1'b0}}, w_lt};
            c_op_mv, c_op_mvnz:  w_alu = w_rdata_y;
            default:             w_alu = '0;
        endcase
    end

    // ld/st address through Ry; fetch and mvi immediates come from PC
    assign w_addr_full = ((r_state == S_MEM) && (w_op != c_op_mvi)) ? w_rdata_y : w_pc;
    assign mem_addr    = w_addr_full[ADDR_W-1:0];
    assign mem_wdata   = w_rdata_x;

    always_comb begin
        w_next_state = r_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        Done         = 1'b0;
        Illegal      = 1'b0;
        w_pc_inc     = 1'b0;
        w_rf_we      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Run) w_next_state = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    w_pc_inc     = 1'b1;
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: w_next_state = S_EXEC;
            S_EXEC:   w_next_state = is_mem_op(w_op) ? S_MEM : S_WB;
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (w_op == c_op_st);
                if (mem_ack) begin
                    w_pc_inc     = (w_op == c_op_mvi);
                    w_next_state = S_WB;
                end
            end
            S_WB: begin
                Done         = 1'b1;
                Illegal      = is_illegal_op(w_op);
                w_rf_we      = writes_rx(w_op, r_z);
                w_next_state = Run ? S_FETCH : S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_ir    <= '0;
            r_a     <= '0;
            r_g     <= '0;
            r_z     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == S_FETCH) && mem_ack) r_ir <= mem_rdata[c_ir_w-1:0];
            if (r_state == S_DECODE) r_a <= w_rdata_x;
            if ((r_state == S_EXEC) && !is_mem_op(w_op)) r_g <= w_alu;
            if ((r_state == S_EXEC) && is_alu_op(w_op)) r_z <= (w_alu == '0);
            if ((r_state == S_MEM) && mem_ack && (w_op != c_op_st)) r_g <= mem_rdata;
        end
    end

    always_comb begin
        BusWires = '0;
        case (r_state)
            S_FETCH, S_MEM: BusWires = w_addr_full;
            S_DECODE:       BusWires = w_rdata_x;
            S_EXEC:         BusWires = w_alu;
            S_WB:           BusWires = r_g;
            default:        BusWires = '0;
        endcase
    end

    assign Tstep   = r_state;
    assign Rx_data = w_rdata_x;
    assign Ry_data = w_rdata_y;

endmodule

`default_nettype wire
